l2_channel_scheduler: RTL
=========================

Name: l2_channel_scheduler

Overview:
Schedules memory requests from the cluster AXI masters onto the L2/DRAM channels. The masters are the Snitch core port plus one port per L1 cache controller. For each request the block:
- derives the target channel from the interleaving bits of the address;
- removes those bits to form the channel-local address;
- arbitrates round-robin between requesters that contend for the same channel;
- enforces a per-channel limit on outstanding transactions.
It sits between the cluster master ports and the per-channel DRAM controllers.

Parameters:
NumReq, 5, number of requesters (1 + NumL1CacheCtrl)
NumChannel, 4, number of L2 channels; power of two, at least 2
AddrWidth, 32, address width
L2BankBeWidth, 64, bytes per L2 beat
Interleave, 128, beats per interleave block
MaxOutstanding, 8, maximum in-flight transactions per channel, 1..255
(derived) ConstBits = clog2(L2BankBeWidth*Interleave) = 13; ChBits = clog2(NumChannel) = 2; SrcW = clog2(NumReq) = 3; CntW = clog2(MaxOutstanding+1) = 4

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_valid_i  in  NumReq  request valid, one bit per requester
req_ready_o  out  NumReq  request accepted, one bit per requester
req_addr_i  in  NumReq*AddrWidth  request address; requester r occupies slice r
req_write_i  in  NumReq  1 = write, 0 = read
ch_valid_o  out  NumChannel  channel request valid
ch_ready_i  in  NumChannel  channel accepts request
ch_addr_o  out  NumChannel*AddrWidth  channel-local address
ch_write_o  out  NumChannel  write flag forwarded from the request
ch_src_o  out  NumChannel*SrcW  index of the requester that was granted
ch_done_i  in  NumChannel  one-cycle pulse: one transaction on the channel has completed
ch_outstanding_o  out  NumChannel*CntW  current in-flight count per channel
err_underflow_o  out  1  sticky flag: ch_done_i arrived while the count was 0

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - Reset is synchronous and active-low on rst_ni.
  - On reset: ch_valid_o = 0, ch_addr_o/ch_write_o/ch_src_o = 0, all counters = 0, all round-robin pointers = 0, err_underflow_o = 0, req_ready_o = 0.
  - Reset asserted mid-operation drops every held request and every count. The environment must also reset the channels.
- Channel mapping (combinational):
  - Target channel of requester r: chan(r) = addr[ConstBits+ChBits-1:ConstBits].
  - Local address: {addr[AddrWidth-1:ConstBits+ChBits], ChBits zero bits, addr[ConstBits-1:0]}.
- Output slot:
  - Each channel has one output register slot.
  - The slot is free when ch_valid_o[c] = 0, or when ch_valid_o[c] & ch_ready_i[c] in the current cycle (pass-through refill, no bubble).
  - While ch_valid_o[c] = 1 and ch_ready_i[c] = 0, the slot holds addr, write and src stable.
- Grant condition for channel c:
  - The slot is free.
  - cnt[c] < MaxOutstanding, using the registered value. A ch_done_i in the same cycle does not enable a grant.
  - At least one r has req_valid_i[r] and chan(r) = c.
- Grant selection and request acceptance:
  - Winner: the first candidate r at or above ptr[c], searching upward with wrap-around.
  - On grant, req_ready_o[winner] = 1 in the same cycle; this is combinational from valid and addr.
  - Each requester targets exactly one channel, so at most one ready per requester.
  - Next edge after grant: slot loads the mapped request, ch_valid_o = 1, ptr[c] = (winner+1) mod NumReq.
  - No grant: ptr[c] is unchanged.
- Latency: one cycle from request acceptance to ch_valid_o.
- Outstanding counter cnt[c]:
  - Increments on grant; a request held in the slot counts as in flight.
  - Decrements on ch_done_i[c].
  - Grant and done in the same cycle: cnt[c] is unchanged.
  - Done with cnt[c] = 0: cnt[c] stays 0 and err_underflow_o is set until reset.
- Output ch_outstanding_o = cnt, registered.
- The requester handshake follows AXI rules: the requester must not drop valid or change addr/write before ready. The block does not check this.
- Independent channels grant in parallel in the same cycle.

Test Plan:
- Single read: requester 0, addr 0x8000_6040 (channel bits [14:13] = 3) → req_ready_o[0] = 1 that cycle; next cycle ch_valid_o[3] = 1, ch_addr_o[3] = 0x8000_0040, ch_src_o[3] = 0, cnt[3] = 1. ch_done_i[3] pulse → cnt[3] = 0.
- Contention: requesters 1, 2, 4 hold addresses mapping to channel 0, ch_ready_i[0] = 1 → grants in order 1, 2, 4, then 1 again if it re-requests. One grant per cycle, no bubbles.
- Backpressure: ch_ready_i[2] = 0 for 5 cycles with the slot full → ch_addr_o/ch_src_o stable, no further req_ready_o for channel 2. ch_ready_i rising → the next requester is loaded in the same cycle.
- Credit limit: MaxOutstanding = 8, 10 requests to channel 1, no done → exactly 8 grants, cnt = 8, ready held low. One ch_done_i → cnt 7, next cycle grant, cnt returns to 8. Done and grant in the same cycle with cnt = 7 → cnt stays 7.
- Parallel channels: requesters 0..3 target channels 0..3 simultaneously → all four ready in one cycle, all ch_valid_o high the next cycle.
- Underflow and reset: ch_done_i[0] with cnt 0 → err_underflow_o = 1, cnt 0. rst_ni = 0 for one edge mid-traffic → all outputs and counts 0, pointers 0, flag cleared.

Source files
------------

// File: rtl/l2_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : l2_channel_scheduler
// Purpose : Maps cluster master requests onto interleaved L2/DRAM channels with
//           per-channel round-robin arbitration and outstanding-credit limits.
// Revision: 1.0 - initial release
// ============================================================================
module l2_channel_scheduler #(
    parameter int NUM_REQ          = 5,
    parameter int NUM_CHANNEL      = 4,
    parameter int ADDR_WIDTH       = 32,
    parameter int L2_BANK_BE_WIDTH = 64,
    parameter int INTERLEAVE       = 128,
    parameter int MAX_OUTSTANDING  = 8,
    localparam int CONST_BITS      = $clog2(L2_BANK_BE_WIDTH * INTERLEAVE),
    localparam int CH_BITS         = $clog2(NUM_CHANNEL),
    localparam int SRC_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [NUM_REQ-1:0]                req_write_i,
    output logic [NUM_CHANNEL-1:0]            ch_valid_o,
    input  logic [NUM_CHANNEL-1:0]            ch_ready_i,
    output logic [NUM_CHANNEL*ADDR_WIDTH-1:0] ch_addr_o,
    output logic [NUM_CHANNEL-1:0]            ch_write_o,
    output logic [NUM_CHANNEL*SRC_W-1:0]      ch_src_o,
    input  logic [NUM_CHANNEL-1:0]            ch_done_i,
    output logic [NUM_CHANNEL*CNT_W-1:0]      ch_outstanding_o,
    output logic                              err_underflow_o
);

    localparam logic [SRC_W:0]     NUM_REQ_EXT = (SRC_W + 1)'(NUM_REQ);
    localparam logic [SRC_W-1:0]   LAST_REQ    = SRC_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]   MAX_CNT     = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_REQ-1:0][CH_BITS-1:0]        w_req_chan;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     w_req_local;
    logic [NUM_CHANNEL-1:0][NUM_REQ-1:0]    w_gnt;
    logic [NUM_CHANNEL-1:0]                 w_uflow;
    logic                                   err_underflow_q;
    logic                                   err_underflow_d;

    // Channel select is the address field just above the interleave block.
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
        logic [ADDR_WIDTH-1:0] w_addr;
        assign w_addr        = req_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_req_chan[r] = w_addr[CONST_BITS +: CH_BITS];
        always_comb begin
            w_req_local[r] = w_addr;
            w_req_local[r][CONST_BITS +: CH_BITS] = '0;
        end
    end

    for (genvar c = 0; c < NUM_CHANNEL; c++) begin : g_chan
        logic                  valid_q, valid_d;
        logic [ADDR_WIDTH-1:0] addr_q, addr_d;
        logic                  write_q, write_d;
        logic [SRC_W-1:0]      src_q, src_d;
        logic [SRC_W-1:0]      ptr_q, ptr_d;
        logic [CNT_W-1:0]      cnt_q, cnt_d;
        logic [NUM_REQ-1:0]    w_cand;
        logic                  w_found;
        logic                  w_grant;
        logic [SRC_W-1:0]      w_win;
        logic [SRC_W:0]        w_idx;

        for (genvar r = 0; r < NUM_REQ; r++) begin : g_cand
            assign w_cand[r] = req_valid_i[r] && (w_req_chan[r] == CH_BITS'(c));
        end

        // Round-robin search starting at the pointer, wrapping past NUM_REQ-1.
        always_comb begin
            w_found = 1'b0;
            w_win   = '0;
            w_idx   = '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx = {1'b0, ptr_q} + k[SRC_W:0];
                if (w_idx >= NUM_REQ_EXT) begin
                    w_idx = w_idx - NUM_REQ_EXT;
                end
                if (!w_found && w_cand[w_idx[SRC_W-1:0]]) begin
                    w_found = 1'b1;
                    w_win   = w_idx[SRC_W-1:0];
                end
            end
        end

        // Credit check uses the registered count; a same-cycle done cannot free a slot.
        assign w_grant  = rst_ni && w_found && (cnt_q < MAX_CNT) &&
                          (!valid_q || ch_ready_i[c]);
        assign w_gnt[c] = w_grant ? (NUM_REQ'(1) << w_win) : '0;
        assign w_uflow[c] = ch_done_i[c] && (cnt_q == '0);

        always_comb begin
            valid_d = valid_q;
            addr_d  = addr_q;
            write_d = write_q;
            src_d   = src_q;
            ptr_d   = ptr_q;
            cnt_d   = cnt_q;
            if (w_grant) begin
                valid_d = 1'b1;
                addr_d  = w_req_local[w_win];
                write_d = req_write_i[w_win];
                src_d   = w_win;
                ptr_d   = (w_win == LAST_REQ) ? '0 : w_win + 1'b1;
            end else if (ch_ready_i[c]) begin
                valid_d = 1'b0;
            end
            if (w_grant && !ch_done_i[c]) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!w_grant && ch_done_i[c] && (cnt_q != '0)) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                addr_q  <= '0;
                write_q <= 1'b0;
                src_q   <= '0;
                ptr_q   <= '0;
                cnt_q   <= '0;
            end else begin
                valid_q <= valid_d;
                addr_q  <= addr_d;
                write_q <= write_d;
                src_q   <= src_d;
                ptr_q   <= ptr_d;
                cnt_q   <= cnt_d;
            end
        end

        assign ch_valid_o[c]                          = valid_q;
        assign ch_addr_o[c*ADDR_WIDTH +: ADDR_WIDTH]  = addr_q;
        assign ch_write_o[c]                          = write_q;
        assign ch_src_o[c*SRC_W +: SRC_W]             = src_q;
        assign ch_outstanding_o[c*CNT_W +: CNT_W]     = cnt_q;
    end

    // A requester maps to exactly one channel, so OR-ing grant columns is safe.
    always_comb begin
        req_ready_o = '0;
        for (int c = 0; c < NUM_CHANNEL; c++) begin
            req_ready_o = req_ready_o | w_gnt[c];
        end
    end

    assign err_underflow_d = err_underflow_q || (|w_uflow);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_underflow_q <= 1'b0;
        end else begin
            err_underflow_q <= err_underflow_d;
        end
    end

    assign err_underflow_o = err_underflow_q;

endmodule
`default_nettype wire
